// File: rtl/pipe_arb.sv
// Single-issue arbiter feeding a shared fixed-latency datapath, with done strobes routed back to requesters.
// Define PIPE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); the default build is round-robin.
module pipe_arb #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 4,
  parameter int SEL_W   = 2
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             hold,
  output logic [N_REQ-1:0] ack,
  output logic             dp_start,
  output logic [SEL_W-1:0] dp_sel,
  output logic [N_REQ-1:0] done,
  output logic             busy
);

  logic [N_REQ-1:0]             elig;
  logic                         gnt_vld;
  logic [SEL_W-1:0]             gnt_idx;
  logic [LATENCY:0]             vld_pipe;
  logic [LATENCY:0][SEL_W-1:0]  idx_pipe;

  // A requester acked this cycle is masked so a still-high req is not granted twice
  assign elig = req & ~ack & {N_REQ{~hold}};

`ifdef PIPE_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(i);
      end
    end
  end
`else
  logic [SEL_W-1:0] last_gnt;

  // Descending scan: the smallest offset past last_gnt is written last and wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      if (elig[(int'(last_gnt) + off) % N_REQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'((int'(last_gnt) + off) % N_REQ);
      end
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst)         last_gnt <= SEL_W'(N_REQ - 1);
    else if (gnt_vld) last_gnt <= gnt_idx;
  end
`endif

  // Stage 0 of the tag chain doubles as the dp_start/dp_sel issue register
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      ack      <= '0;
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      ack         <= gnt_vld ? (N_REQ'(1) << gnt_idx) : '0;
      vld_pipe    <= {vld_pipe[LATENCY-1:0], gnt_vld};
      idx_pipe[0] <= gnt_vld ? gnt_idx : idx_pipe[0];
      for (int j = 1; j <= LATENCY; j++) idx_pipe[j] <= idx_pipe[j-1];
    end
  end

  assign dp_start = vld_pipe[0];
  assign dp_sel   = idx_pipe[0];
  assign busy     = |vld_pipe[LATENCY-1:0];
  assign done     = vld_pipe[LATENCY] ? (N_REQ'(1) << idx_pipe[LATENCY]) : '0;

endmodule
